// File: rtl/xor_mem_pkg.sv
// Purpose: shared types and bank-indexing helpers for the XOR multiport memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xor_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    // Each row owns one bank per foreign write port plus one per read port.
    function automatic int banks_per_row(input int nw, input int nr);
        return nw - 1 + nr;
    endfunction

    // Consumers 0..NW-1 are write ports and NW.. are read ports. A row keeps
    // no bank for its own write port, so consumers above the row shift down.
    function automatic int bank_idx(input int row, input int consumer);
        return (consumer < row) ? consumer : consumer - 1;
    endfunction

    // Inverse of bank_idx: which consumer a given bank of a row serves.
    function automatic int bank_consumer(input int row, input int bank);
        return (bank < row) ? bank : bank + 1;
    endfunction

endpackage

// File: rtl/simple_dual_port_memory.sv
// Purpose: 1R1W synchronous RAM bank; one write port and one read port.
// Latency: read data registered, valid 1 cycle after rd_en.
// Backpressure: none; accepts a read and a write every cycle.
module simple_dual_port_memory #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Storage write plus registered read; a same-address collision returns old data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/xor_mem_clear_fsm.sv
// Purpose: CLEAR/READY controller that sweeps every address to zero.
// Latency: sweep lasts exactly DEPTH cycles; clear_req acts on the next edge.
// Backpressure: ready is low for the whole sweep; requests are ignored then.
module xor_mem_clear_fsm
    import xor_mem_pkg::*;
#(
    parameter int DEPTH          = 1024,
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter int AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear_req,
    output logic          ready,
    output logic          sweep_en,
    output logic [AW-1:0] sweep_addr
);

    // One extra bit so a power-of-two DEPTH terminates without wrapping.
    localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_e      state_q, state_d;
    logic [AW:0] cnt_q, cnt_d;

    // Next-state: walk the counter through every address, then accept traffic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            READY: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset restarts any sweep from address 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : READY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ready      = (state_q == READY);
    assign sweep_en   = (state_q == CLEAR);
    assign sweep_addr = cnt_q[AW-1:0];

endmodule

// File: rtl/xor_multiport_memory_rw.sv
// Purpose: NW-write / NR-read XOR multiport RAM with clear sweep, conflict arbitration and bypass.
// Latency: writes commit 1 cycle after acceptance; read data valid 2 cycles after rd_en.
// Backpressure: requests accepted only while ready=1; suppressed writes flagged on wr_conflict.
module xor_multiport_memory_rw
    import xor_mem_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 1024,
    parameter int NW             = 2,
    parameter int NR             = 2,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int AW            = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_req,
    output logic                     ready,
    input  logic [NW-1:0]            wr_en,
    input  logic [NW-1:0][AW-1:0]    wr_addr,
    input  logic [NW-1:0][WIDTH-1:0] wr_data,
    output logic [NW-1:0]            wr_conflict,
    input  logic [NR-1:0]            rd_en,
    input  logic [NR-1:0][AW-1:0]    rd_addr,
    output logic [NR-1:0][WIDTH-1:0] rd_data,
    output logic [NR-1:0]            rd_valid
);

    localparam int          BPR     = banks_per_row(NW, NR);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic          sweep_en;
    logic [AW-1:0] sweep_addr;

    xor_mem_clear_fsm #(
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET),
        .AW             (AW)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .ready      (ready),
        .sweep_en   (sweep_en),
        .sweep_addr (sweep_addr)
    );

    logic [WIDTH-1:0] bank_rd [NW][BPR];

    logic [NW-1:0]            wr_ok, wr_win;
    logic [NW-1:0]            wr_vld_q, wr_vld_d;
    logic [NW-1:0]            wr_conflict_q, wr_conflict_d;
    logic [NW-1:0][AW-1:0]    wr_addr_q, wr_addr_d;
    logic [NW-1:0][WIDTH-1:0] wr_data_q, wr_data_d;

    logic [NW-1:0]            commit_en;
    logic [NW-1:0][WIDTH-1:0] enc;
    logic [NW-1:0]            commit_vld_q, commit_vld_d;
    logic [NW-1:0][AW-1:0]    commit_addr_q, commit_addr_d;
    logic [NW-1:0][WIDTH-1:0] commit_val_q, commit_val_d;

    logic [NR-1:0]            rd_ok;
    logic [NR-1:0]            rd_vld_q, rd_vld_d;
    logic [NR-1:0][AW-1:0]    rd_addr_q, rd_addr_d;
    logic [NR-1:0]            rd_valid_q, rd_valid_d;
    logic [NR-1:0][WIDTH-1:0] rd_data_q, rd_data_d;

    // Write accept: range check, then lowest-index port wins a shared address.
    always_comb begin
        wr_ok  = '0;
        wr_win = '0;
        for (int w = 0; w < NW; w++) begin
            wr_ok[w] = ready && wr_en[w] && ({1'b0, wr_addr[w]} < DEPTH_L);
        end
        for (int w = 0; w < NW; w++) begin
            wr_win[w] = wr_ok[w];
            for (int v = 0; v < w; v++) begin
                if (wr_ok[v] && (wr_addr[v] == wr_addr[w])) begin
                    wr_win[w] = 1'b0;
                end
            end
        end
        wr_vld_d      = wr_win;
        wr_conflict_d = wr_ok & ~wr_win;
        wr_addr_d     = wr_addr;
        wr_data_d     = wr_data;
    end

    // Write commit: encode data against the other rows. A row that committed
    // the same address on the edge the feedback read was issued is taken from
    // the commit register, so the result is independent of bank collision mode.
    always_comb begin
        logic [WIDTH-1:0] fb;
        fb        = '0;
        enc       = '0;
        commit_en = '0;
        for (int w = 0; w < NW; w++) begin
            enc[w] = wr_data_q[w];
            for (int v = 0; v < NW; v++) begin
                if (v != w) begin
                    fb = bank_rd[v][bank_idx(v, w)];
                    if (commit_vld_q[v] && (commit_addr_q[v] == wr_addr_q[w])) begin
                        fb = commit_val_q[v];
                    end
                    enc[w] = enc[w] ^ fb;
                end
            end
            // The sweep owns the bank write ports; everything is zeroed anyway.
            commit_en[w] = wr_vld_q[w] && !sweep_en && !rst;
        end
        commit_vld_d  = commit_en;
        commit_addr_d = wr_addr_q;
        commit_val_d  = enc;
    end

    // Read path: XOR one bank per row, with the same commit-register bypass.
    always_comb begin
        logic [WIDTH-1:0] rd_x;
        rd_x      = '0;
        rd_ok     = '0;
        rd_data_d = rd_data_q;
        for (int r = 0; r < NR; r++) begin
            rd_ok[r] = ready && rd_en[r];
            rd_x     = '0;
            for (int w = 0; w < NW; w++) begin
                if (commit_vld_q[w] && (commit_addr_q[w] == rd_addr_q[r])) begin
                    rd_x = rd_x ^ commit_val_q[w];
                end else begin
                    rd_x = rd_x ^ bank_rd[w][bank_idx(w, NW + r)];
                end
            end
            if (rd_vld_q[r]) begin
                rd_data_d[r] = rd_x;
            end
        end
        rd_vld_d   = rd_ok;
        rd_addr_d  = rd_addr;
        rd_valid_d = rd_vld_q;
    end

    // Pipeline registers; reset drops every enable and the visible outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_vld_q      <= '0;
            wr_conflict_q <= '0;
            commit_vld_q  <= '0;
            rd_vld_q      <= '0;
            rd_valid_q    <= '0;
            rd_data_q     <= '0;
        end else begin
            wr_vld_q      <= wr_vld_d;
            wr_conflict_q <= wr_conflict_d;
            commit_vld_q  <= commit_vld_d;
            rd_vld_q      <= rd_vld_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
        end
        wr_addr_q     <= wr_addr_d;
        wr_data_q     <= wr_data_d;
        commit_addr_q <= commit_addr_d;
        commit_val_q  <= commit_val_d;
        rd_addr_q     <= rd_addr_d;
    end

    // Bank array: every bank of a row receives the row's write (or the sweep zero).
    for (genvar w = 0; w < NW; w++) begin : g_row
        logic             bank_we;
        logic [AW-1:0]    bank_wa;
        logic [WIDTH-1:0] bank_wd;

        assign bank_we = (sweep_en && !rst) || commit_en[w];
        assign bank_wa = sweep_en ? sweep_addr : wr_addr_q[w];
        assign bank_wd = sweep_en ? '0 : enc[w];

        for (genvar b = 0; b < BPR; b++) begin : g_bank
            localparam int CONS = bank_consumer(w, b);
            logic          bank_re;
            logic [AW-1:0] bank_ra;

            if (CONS < NW) begin : g_fb
                assign bank_re = wr_ok[CONS];
                assign bank_ra = wr_addr[CONS];
            end else begin : g_rd
                assign bank_re = rd_ok[CONS - NW];
                assign bank_ra = rd_addr[CONS - NW];
            end

            simple_dual_port_memory #(
                .WIDTH (WIDTH),
                .DEPTH (DEPTH),
                .AW    (AW)
            ) u_bank (
                .clk     (clk),
                .wr_en   (bank_we),
                .wr_addr (bank_wa),
                .wr_data (bank_wd),
                .rd_en   (bank_re),
                .rd_addr (bank_ra),
                .rd_data (bank_rd[w][b])
            );
        end
    end

    assign wr_conflict = wr_conflict_q;
    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_xor_multiport_memory_rw.sv
// Purpose: directed scoreboard bench for xor_multiport_memory_rw (NW=3, NR=2, DEPTH=16).
// Latency: expects read data 2 cycles after rd_en, wr_conflict 1 cycle after the write.
// Backpressure: stimulus waits on ready with bounded loops.
module tb_xor_multiport_memory_rw;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int NW    = 3;
    localparam int NR    = 2;
    localparam int AW    = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     clear_req = 1'b0;
    logic                     ready;
    logic [NW-1:0]            wr_en = '0;
    logic [NW-1:0][AW-1:0]    wr_addr = '0;
    logic [NW-1:0][WIDTH-1:0] wr_data = '0;
    logic [NW-1:0]            wr_conflict;
    logic [NR-1:0]            rd_en = '0;
    logic [NR-1:0][AW-1:0]    rd_addr = '0;
    logic [NR-1:0][WIDTH-1:0] rd_data;
    logic [NR-1:0]            rd_valid;

    xor_multiport_memory_rw #(
        .WIDTH          (WIDTH),
        .DEPTH          (DEPTH),
        .NW             (NW),
        .NR             (NR),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (clear_req),
        .ready       (ready),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_conflict (wr_conflict),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        int          due;
    } rd_exp_t;

    rd_exp_t     rdq0[$];
    rd_exp_t     rdq1[$];
    logic [2:0]  confq[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Start a new stimulus cycle; conf is the wr_conflict expected after this cycle's edge.
    task automatic cyc_start(input logic [2:0] conf);
        @(negedge clk);
        #1;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        rd_en     = '0;
        rd_addr   = '0;
        clear_req = 1'b0;
        confq.push_back(conf);
    endtask

    task automatic wr(input int p, input logic [3:0] a, input logic [31:0] d);
        wr_en[p]   = 1'b1;
        wr_addr[p] = a;
        wr_data[p] = d;
    endtask

    task automatic rd(input int p, input logic [3:0] a, input logic [31:0] e);
        rd_exp_t x;
        rd_en[p]   = 1'b1;
        rd_addr[p] = a;
        x.dat = e;
        x.due = cyc + 2;
        if (p == 0) rdq0.push_back(x);
        else        rdq1.push_back(x);
    endtask

    // Monitor: compares outputs against the scoreboard queues on every falling edge.
    initial begin
        logic [2:0] c;
        rd_exp_t    e;
        forever begin
            @(negedge clk);
            if (confq.size() > 0) begin
                c = confq.pop_front();
                check("wr_conflict", 32'(wr_conflict), 32'(c));
            end
            if (rd_valid[0]) begin
                if (rdq0.size() == 0) begin
                    check("rd0_unexpected_valid", 32'(rd_valid[0]), 32'd0);
                end else begin
                    e = rdq0.pop_front();
                    check("rd0_data", rd_data[0], e.dat);
                    check("rd0_latency", 32'(cyc), 32'(e.due));
                end
            end else if (rdq0.size() > 0 && rdq0[0].due <= cyc) begin
                e = rdq0.pop_front();
                check("rd0_valid_missing", 32'(rd_valid[0]), 32'd1);
            end
            if (rd_valid[1]) begin
                if (rdq1.size() == 0) begin
                    check("rd1_unexpected_valid", 32'(rd_valid[1]), 32'd0);
                end else begin
                    e = rdq1.pop_front();
                    check("rd1_data", rd_data[1], e.dat);
                    check("rd1_latency", 32'(cyc), 32'(e.due));
                end
            end else if (rdq1.size() > 0 && rdq1[0].due <= cyc) begin
                e = rdq1.pop_front();
                check("rd1_valid_missing", 32'(rd_valid[1]), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    // Count cycles until ready rises (bounded).
    task automatic wait_ready(output int n);
        n = 0;
        while (!ready && n < 100) begin
            cyc_start(3'b000);
            n++;
        end
    endtask

    initial begin
        int n;

        // Reset values
        repeat (3) cyc_start(3'b000);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_wr_conflict", 32'(wr_conflict), 32'd0);
        check("reset_rd_data0", rd_data[0], 32'd0);
        check("reset_rd_data1", rd_data[1], 32'd0);

        // Power-on sweep takes DEPTH cycles
        cyc_start(3'b000);
        rst = 1'b0;
        wait_ready(n);
        check("reset_sweep_cycles", 32'(n), 32'd16);

        // Every address reads zero on both ports
        for (int a = 0; a < 16; a++) begin
            cyc_start(3'b000);
            rd(0, 4'(a), 32'h0);
            rd(1, 4'(15 - a), 32'h0);
        end

        // Parallel writes with a same-address conflict on port 2
        cyc_start(3'b100);
        wr(0, 4'd5, 32'hA5A5A5A5);
        wr(1, 4'd9, 32'h12345678);
        wr(2, 4'd5, 32'hFFFF0000);
        cyc_start(3'b000);
        rd(0, 4'd5, 32'hA5A5A5A5);
        rd(1, 4'd5, 32'hA5A5A5A5);
        cyc_start(3'b000);
        rd(0, 4'd9, 32'h12345678);
        rd(1, 4'd9, 32'h12345678);
        cyc_start(3'b000);
        rd(0, 4'd5, 32'hA5A5A5A5);
        rd(1, 4'd9, 32'h12345678);

        // Bypass: same-edge read sees old data, next-edge read sees the write
        cyc_start(3'b000);
        wr(0, 4'd3, 32'hDEADBEEF);
        rd(1, 4'd3, 32'h0);
        cyc_start(3'b000);
        rd(0, 4'd3, 32'hDEADBEEF);
        rd(1, 4'd3, 32'hDEADBEEF);
        cyc_start(3'b000);
        rd(0, 4'd3, 32'hDEADBEEF);
        wr(2, 4'd4, 32'h0BADF00D);
        cyc_start(3'b000);
        rd(1, 4'd4, 32'h0BADF00D);

        // Alternating ports writing one address on consecutive cycles
        for (int k = 0; k < 4; k++) begin
            cyc_start(3'b000);
            wr(k % 2, 4'd7, 32'(k + 1));
            rd(0, 4'd7, 32'(k));
            rd(1, 4'd7, 32'(k));
        end
        cyc_start(3'b000);
        rd(0, 4'd7, 32'd4);
        rd(1, 4'd7, 32'd4);
        cyc_start(3'b000);
        rd(0, 4'd7, 32'd4);

        // Fill, then clear: traffic during the sweep is ignored
        for (int a = 0; a < 16; a++) begin
            cyc_start(3'b000);
            wr(a % 3, 4'(a), 32'hFF);
        end
        cyc_start(3'b000);
        clear_req = 1'b1;
        rd(0, 4'd2, 32'hFF);
        n = 0;
        cyc_start(3'b000);
        while (!ready && n < 100) begin
            n++;
            wr(0, 4'd1, 32'hAB);
            rd_en     = 2'b11;
            rd_addr   = {4'd1, 4'd6};
            clear_req = 1'b1;
            cyc_start(3'b000);
        end
        check("clear_req_sweep_cycles", 32'(n), 32'd16);
        for (int a = 0; a < 16; a++) begin
            cyc_start(3'b000);
            rd(0, 4'(a), 32'h0);
            rd(1, 4'(a), 32'h0);
        end

        // Reset during a sweep at address 8 restarts it
        cyc_start(3'b000);
        wr(0, 4'd12, 32'h55);
        cyc_start(3'b000);
        wr(1, 4'd2, 32'h77);
        cyc_start(3'b000);
        rd(0, 4'd12, 32'h55);
        rd(1, 4'd2, 32'h77);
        cyc_start(3'b000);
        clear_req = 1'b1;
        repeat (9) cyc_start(3'b000);
        rst = 1'b1;
        cyc_start(3'b000);
        rst = 1'b0;
        check("rst_mid_sweep_ready", 32'(ready), 32'd0);
        wait_ready(n);
        check("rst_mid_sweep_cycles", 32'(n), 32'd16);
        cyc_start(3'b000);
        rd(0, 4'd12, 32'h0);
        rd(1, 4'd2, 32'h0);

        repeat (4) cyc_start(3'b000);
        check("rd0_queue_drained", 32'(rdq0.size()), 32'd0);
        check("rd1_queue_drained", 32'(rdq1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
